// File: rtl/dsconv_block_bn_sequencer_if.sv
// Bundle of every non-clock signal of the BN sequencer.
//   slave  : the sequencer itself (takes params/pixels/BN results, drives BN unit and output)
//   master : the environment (parameter writer, pixel source, BN unit, result sink)
// Signals:
//   param_we/param_addr/param_p/param_q : coefficient write port (p Q9, q scaled Q18)
//   start                               : begin one feature map
//   in_valid/in_pixel/in_ready          : channel-major pixel stream
//   bn_start/bn_x/bn_p/bn_q             : issue to BN unit
//   bn_pixel/bn_ready                   : BN unit result
//   out_valid/out_pixel/out_channel/out_last : tagged result stream
//   busy/done                           : status
interface dsconv_block_bn_sequencer_if #(
   parameter int unsigned CH_W = 3
);
   logic                     param_we;
   logic [CH_W-1:0]          param_addr;
   logic signed [17:0]       param_p;
   logic signed [35:0]       param_q;
   logic                     start;
   logic                     in_valid;
   logic signed [17:0]       in_pixel;
   logic                     in_ready;
   logic                     bn_start;
   logic signed [17:0]       bn_x;
   logic signed [17:0]       bn_p;
   logic signed [35:0]       bn_q;
   logic signed [17:0]       bn_pixel;
   logic                     bn_ready;
   logic                     out_valid;
   logic signed [17:0]       out_pixel;
   logic [CH_W-1:0]          out_channel;
   logic                     out_last;
   logic                     busy;
   logic                     done;

   modport slave (
      input  param_we, param_addr, param_p, param_q, start, in_valid, in_pixel,
             bn_pixel, bn_ready,
      output in_ready, bn_start, bn_x, bn_p, bn_q, out_valid, out_pixel, out_channel,
             out_last, busy, done
   );

   modport master (
      output param_we, param_addr, param_p, param_q, start, in_valid, in_pixel,
             bn_pixel, bn_ready,
      input  in_ready, bn_start, bn_x, bn_p, bn_q, out_valid, out_pixel, out_channel,
             out_last, busy, done
   );
endinterface

// File: rtl/dsconv_block_bn_sequencer.sv
// Initiator-side controller for the batch-normalization unit of a depthwise-separable block.
// Holds per-channel folded BN coefficients {p, q}, accepts a channel-major pixel stream,
// issues one bn_start per pixel with that channel's coefficients, and returns each BN result
// tagged with its channel and a last-pixel marker.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bus_io : sequencer side (slave modport) of dsconv_block_bn_sequencer_if
module dsconv_block_bn_sequencer #(
   parameter int unsigned CH_NUM  = 8,
   parameter int unsigned PIX_NUM = 16,
   parameter int unsigned CH_W    = $clog2(CH_NUM)
) (
   input logic                          clk,
   input logic                          rst,
   dsconv_block_bn_sequencer_if.slave   bus_io
);

   localparam int unsigned PIX_W = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NUM - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_NUM - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e             state_q;
   logic               in_ready_q;
   logic               busy_q;
   logic               done_q;
   logic [PIX_W-1:0]   pix_cnt_q;
   logic [CH_W-1:0]    ch_cnt_q;

   logic signed [17:0] p_q [CH_NUM];
   logic signed [35:0] q_q [CH_NUM];

   // Issue stage
   logic               bn_start_q;
   logic signed [17:0] bn_x_q;
   logic signed [17:0] bn_p_q;
   logic signed [35:0] bn_q_q;
   logic [CH_W-1:0]    iss_ch_q;
   logic               iss_last_q;

   // Return stage, aligned with the BN unit's registered result
   logic               out_valid_q;
   logic [CH_W-1:0]    out_ch_q;
   logic               out_last_q;

   logic               accept;
   logic               last_pix;

   // in_ready_q is only ever set in StRun, so it doubles as the state qualifier
   assign accept   = bus_io.in_valid && in_ready_q;
   assign last_pix = (ch_cnt_q == CH_LAST) && (pix_cnt_q == PIX_LAST);

   // Control FSM with registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pix_cnt_q  <= '0;
         ch_cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus_io.start) begin
                  state_q    <= StRun;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  pix_cnt_q  <= '0;
                  ch_cnt_q   <= '0;
               end
            end
            StRun: begin
               if (accept) begin
                  if (last_pix) begin
                     state_q    <= StDrain;
                     in_ready_q <= 1'b0;
                  end
                  if (pix_cnt_q == PIX_LAST) begin
                     pix_cnt_q <= '0;
                     ch_cnt_q  <= (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CH_W'(1);
                  end else begin
                     pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                  end
               end
            end
            StDrain: begin
               if (out_valid_q && out_last_q) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q    <= StIdle;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   // Coefficient file; a write in the start cycle lands before the first pixel can issue
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(CH_NUM); i++) begin
            p_q[i] <= '0;
            q_q[i] <= '0;
         end
      end else if (bus_io.param_we && (state_q == StIdle)) begin
         p_q[bus_io.param_addr] <= bus_io.param_p;
         q_q[bus_io.param_addr] <= bus_io.param_q;
      end
   end

   // Issue and return pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         bn_start_q  <= 1'b0;
         bn_x_q      <= '0;
         bn_p_q      <= '0;
         bn_q_q      <= '0;
         iss_ch_q    <= '0;
         iss_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
      end else begin
         bn_start_q <= accept;
         if (accept) begin
            bn_x_q     <= bus_io.in_pixel;
            bn_p_q     <= p_q[ch_cnt_q];
            bn_q_q     <= q_q[ch_cnt_q];
            iss_ch_q   <= ch_cnt_q;
            iss_last_q <= last_pix;
         end
         // bn_ready is sticky, so the delayed bn_start is the only per-sample valid
         out_valid_q <= bn_start_q;
         out_last_q  <= bn_start_q && iss_last_q;
         if (bn_start_q) begin
            out_ch_q <= iss_ch_q;
         end
      end
   end

   assign bus_io.in_ready    = in_ready_q;
   assign bus_io.busy        = busy_q;
   assign bus_io.done        = done_q;
   assign bus_io.bn_start    = bn_start_q;
   assign bus_io.bn_x        = bn_x_q;
   assign bus_io.bn_p        = bn_p_q;
   assign bus_io.bn_q        = bn_q_q;
   assign bus_io.out_valid   = out_valid_q;
   assign bus_io.out_channel = out_ch_q;
   assign bus_io.out_last    = out_last_q;
   // Gated so that the output reads 0 whenever no result is presented
   assign bus_io.out_pixel   = out_valid_q ? bus_io.bn_pixel : '0;

endmodule
